// File: rtl/adc_pkg.sv
// ============================================================================
// adc_pkg : shared constants and FSM state type for the SPI ADC capture block
// Revision: 1.0
// ============================================================================
`default_nettype none

package adc_pkg;
    localparam int ADC_BITS   = 12;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
    localparam int MIDSCALE   = 2048;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TAIL  = 3'd3,
        ST_DONE  = 3'd4
    } adc_state_t;
endpackage

`default_nettype wire

// File: rtl/adc_sample_timer.sv
// ============================================================================
// adc_sample_timer : free-running 0..SAMPLE_DIV-1 counter, tick on terminal count
// Revision: 1.0
// ============================================================================
`default_nettype none

module adc_sample_timer #(
    parameter int SAMPLE_DIV = 10000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);
endmodule

`default_nettype wire

// File: rtl/adc_spi_capture.sv
// ============================================================================
// adc_spi_capture : paced AD7476-style SPI read, offset-binary to Q-format Uk.
// Optional test ramp source enabled by defining ADC_TESTPAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adc_spi_capture
    import adc_pkg::*;
#(
    parameter int N          = 25,
    parameter int F          = 12,
    parameter int DIV        = 4,
    parameter int SAMPLE_DIV = 10000
) (
    input  logic         Clk,
    input  logic         Reset,
`ifdef ADC_TESTPAT_EN
    input  logic         Test_Sel,
`endif
    input  logic         ADC_SDATA,
    output logic         ADC_CS_n,
    output logic         ADC_SCLK,
    output logic [N-1:0] Uk,
    output logic         Bandera_ADC,
    output logic         Frame_Err
);
    localparam int PW       = $clog2(2 * DIV);
    localparam int SCALE_SH = F - (ADC_BITS - 1);
    localparam logic [PW-1:0] HALF_END = PW'(DIV - 1);
    localparam logic [PW-1:0] FULL_END = PW'(2 * DIV - 1);
    localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

    generate
        if (SAMPLE_DIV < 34 * DIV + 3 || DIV < 2 || F < 11 || N < F + 2) begin : g_param_check
            $error("adc_spi_capture: illegal parameter combination");
        end
    endgenerate

    adc_state_t            state;
    logic [PW-1:0]         phase;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic                  tick;

    logic [ADC_BITS-1:0]   code;
    logic signed [ADC_BITS:0] diff;
    logic signed [N-1:0]   sample;
    logic                  frame_bad;

    adc_sample_timer #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_timer (
        .clk  (Clk),
        .rst  (Reset),
        .tick (tick)
    );

`ifdef ADC_TESTPAT_EN
    logic [ADC_BITS-1:0] ramp;

    always_comb begin
        code      = Test_Sel ? ramp : shift[ADC_BITS-1:0];
        frame_bad = Test_Sel ? 1'b0 : (shift[FRAME_BITS-1:ADC_BITS] != '0);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ramp <= '0;
        end else if (state == ST_DONE && Test_Sel) begin
            ramp <= ramp + 1'b1;
        end
    end
`else
    always_comb begin
        code      = shift[ADC_BITS-1:0];
        frame_bad = (shift[FRAME_BITS-1:ADC_BITS] != '0);
    end
`endif

    // Offset binary to two's complement, then scale so that full scale is +/-1.0.
    always_comb begin
        diff   = signed'({1'b0, code}) - signed'((ADC_BITS + 1)'(MIDSCALE));
        sample = {{(N - ADC_BITS - 1){diff[ADC_BITS]}}, diff} <<< SCALE_SH;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            phase       <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            ADC_CS_n    <= 1'b1;
            ADC_SCLK    <= 1'b1;
            Uk          <= '0;
            Bandera_ADC <= 1'b0;
            Frame_Err   <= 1'b0;
        end else begin
            Bandera_ADC <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state    <= ST_LEAD;
                        ADC_CS_n <= 1'b0;
                        phase    <= '0;
                    end
                end
                ST_LEAD: begin
                    if (phase == HALF_END) begin
                        state    <= ST_SHIFT;
                        ADC_SCLK <= 1'b0;
                        phase    <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Capture on the cycle SCLK rises; the ADC updated data at the fall.
                    if (phase == HALF_END) begin
                        ADC_SCLK <= 1'b1;
                        shift    <= {shift[FRAME_BITS-2:0], ADC_SDATA};
                    end
                    if (phase == FULL_END) begin
                        phase <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_TAIL;
                        end else begin
                            ADC_SCLK <= 1'b0;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (phase == HALF_END) begin
                        ADC_CS_n <= 1'b1;
                        state    <= ST_DONE;
                        phase    <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_DONE: begin
                    Uk          <= sample;
                    Frame_Err   <= frame_bad;
                    Bandera_ADC <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_adc_spi_capture.sv
// ============================================================================
// tb_adc_spi_capture : ADC model + frame-timing reference for adc_spi_capture
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adc_spi_capture;
    localparam int N          = 25;
    localparam int F          = 12;
    localparam int DIV        = 4;
    localparam int SAMPLE_DIV = 300;
    localparam int LATENCY    = 34 * DIV + 2;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         ADC_SDATA = 1'b0;
    logic         ADC_CS_n;
    logic         ADC_SCLK;
    logic [N-1:0] Uk;
    logic         Bandera_ADC;
    logic         Frame_Err;
`ifdef ADC_TESTPAT_EN
    logic         test_sel = 1'b0;
`endif

    adc_spi_capture #(
        .N          (N),
        .F          (F),
        .DIV        (DIV),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
`ifdef ADC_TESTPAT_EN
        .Test_Sel    (test_sel),
`endif
        .ADC_SDATA   (ADC_SDATA),
        .ADC_CS_n    (ADC_CS_n),
        .ADC_SCLK    (ADC_SCLK),
        .Uk          (Uk),
        .Bandera_ADC (Bandera_ADC),
        .Frame_Err   (Frame_Err)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc;

    logic [15:0] stim_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] cur_frame = 16'h0;
    int          bit_idx = 15;
    logic [N-1:0] model_uk = '0;
    logic         model_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] conv(input logic [15:0] fr);
        int d;
        logic signed [31:0] v;
        d = int'(fr[11:0]) - 2048;
        v = d * (1 << (F - 11));
        return v[N-1:0];
    endfunction

    function automatic logic [15:0] rand_frame();
        logic [15:0] f;
        f[11:0]  = 12'($urandom);
        f[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        return f;
    endfunction

    // Cycle index since reset release; rate counter equals cyc mod SAMPLE_DIV.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ADC model: a new frame per CS fall, next bit MSB-first on each SCLK fall.
    always @(negedge ADC_CS_n) begin
        if (stim_q.size() > 0) cur_frame = stim_q.pop_front();
        else                   cur_frame = rand_frame();
        exp_q.push_back(cur_frame);
        bit_idx = 15;
    end

    always @(negedge ADC_SCLK) begin
        if (!ADC_CS_n) begin
            ADC_SDATA = cur_frame[bit_idx];
            if (bit_idx > 0) bit_idx--;
        end
    end

    // Per-cycle reference: pin behaviour derived from the phase since the last tick.
    always @(negedge Clk) begin
        int r, p;
        logic active, exp_cs, exp_sclk, exp_str;
        if (Reset) begin
            check("rst_cs_n", 32'(ADC_CS_n), 32'd1);
            check("rst_sclk", 32'(ADC_SCLK), 32'd1);
            check("rst_strobe", 32'(Bandera_ADC), 32'd0);
            check("rst_uk", 32'(Uk), 32'd0);
            check("rst_ferr", 32'(Frame_Err), 32'd0);
        end else begin
            r        = cyc - (SAMPLE_DIV - 1);
            active   = (r >= 0);
            p        = active ? (r % SAMPLE_DIV) : -1;
            exp_cs   = !(active && p >= 1 && p <= 34 * DIV);
            exp_sclk = !(active && p >= DIV + 1 && p <= 33 * DIV && ((p - DIV - 1) % (2 * DIV)) < DIV);
            exp_str  = active && (p == LATENCY);
            if (exp_str) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL frame_queue: got empty expected a captured frame (cyc %0d)", cyc);
                end else begin
                    logic [15:0] f;
                    f = exp_q.pop_front();
                    model_uk  = conv(f);
                    model_err = (f[15:12] != 4'h0);
                end
            end
            check("cs_n", 32'(ADC_CS_n), 32'(exp_cs));
            check("sclk", 32'(ADC_SCLK), 32'(exp_sclk));
            check("strobe", 32'(Bandera_ADC), 32'(exp_str));
            check("uk", 32'(Uk), 32'(model_uk));
            check("frame_err", 32'(Frame_Err), 32'(model_err));
        end
    end

    task automatic wait_strobe(output int at_cyc);
        bit found = 0;
        at_cyc = -1;
        for (int i = 0; i < 2 * SAMPLE_DIV && !found; i++) begin
            @(negedge Clk);
            if (Bandera_ADC === 1'b1) begin
                found  = 1;
                at_cyc = cyc;
            end
        end
        if (!found) check("strobe_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_frame(input logic [N-1:0] uk_exp, input logic err_exp, input string tag);
        int c;
        wait_strobe(c);
        check({tag, "_uk"}, 32'(Uk), 32'(uk_exp));
        check({tag, "_ferr"}, 32'(Frame_Err), 32'(err_exp));
    endtask

    initial begin
        int c;
        int rises;
        logic prev;
        bit cs_seen;

        stim_q.push_back(16'h0800);
        stim_q.push_back(16'h0FFF);
        stim_q.push_back(16'h0000);
        stim_q.push_back(16'h0801);
        stim_q.push_back(16'h1ABC);

        repeat (3) @(posedge Clk);
        #2 Reset = 1'b0;

        wait_strobe(c);
        check("first_latency", 32'(c), 32'(SAMPLE_DIV - 1 + LATENCY));
        check("mid_uk", 32'(Uk), 32'h0000000);
        check("mid_ferr", 32'(Frame_Err), 32'd0);
        expect_frame(25'h0000FFE, 1'b0, "max");
        expect_frame(25'h1FFF000, 1'b0, "min");
        expect_frame(25'h0000002, 1'b0, "mid_p1");
        expect_frame(25'h0000578, 1'b1, "lead_err");

        for (int k = 0; k < 40; k++) wait_strobe(c);

        // Abort a frame after its 7th SCLK rise.
        cs_seen = 0;
        for (int i = 0; i < 2 * SAMPLE_DIV && !cs_seen; i++) begin
            @(negedge Clk);
            if (ADC_CS_n === 1'b0) cs_seen = 1;
        end
        if (!cs_seen) check("cs_timeout", 32'd0, 32'd1);
        rises = 0;
        prev  = ADC_SCLK;
        for (int i = 0; i < 40 * DIV && rises < 7; i++) begin
            @(negedge Clk);
            if (ADC_SCLK && !prev) rises++;
            prev = ADC_SCLK;
        end
        check("abort_rises", 32'(rises), 32'd7);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("abort_cs_n", 32'(ADC_CS_n), 32'd1);
        check("abort_sclk", 32'(ADC_SCLK), 32'd1);
        exp_q.delete();
        model_uk  = '0;
        model_err = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b0;

        wait_strobe(c);
        check("post_rst_latency", 32'(c), 32'(SAMPLE_DIV - 1 + LATENCY));
        for (int k = 0; k < 3; k++) wait_strobe(c);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
